ec_x_seq: RTL and testbench

EC_X_SEQ -- requirements
Module: ec_x_seq

---
 rtl/ec_x_seq.sv | 143 ++++++++++++++
 tb/tb_ec_x_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_x_seq.sv
// ec_x_seq: micro-program sequencer for the X register and the
// modular-arithmetic unit. It steps through instructions held in an external
// synchronous ROM. For each instruction it loads X, starts the arithmetic unit
// and waits for that unit to complete, with a watchdog on the wait.
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   start        one-cycle run request (sampled in IDLE only)
//   abort        cancel a running program (any non-IDLE state)
//   prog_len     number of instructions, captured on an accepted start
//   rom_addr     instruction address (always equals pc)
//   rom_data     instruction: [7] end, [6:5] reserved, [4:3] ma_op, [2:0] x_src
//   x_op/x_en    X source select and load enable
//   x_clr        X synchronous clear
//   ma_op        arithmetic op code (holds last latched value)
//   ma_start     one-cycle start pulse to the arithmetic unit
//   ma_done      one-cycle completion pulse from the arithmetic unit
//   busy         high in every state except IDLE
//   done / err   normal-completion pulse / watchdog-timeout pulse
module ec_x_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] prog_len,
    output logic [5:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [2:0] x_op,
    output logic       x_en,
    output logic       x_clr,
    output logic [1:0] ma_op,
    output logic       ma_start,
    input  logic       ma_done,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned PC_W = 6;
    localparam int unsigned WD_W = 8;
    localparam logic [WD_W-1:0] WD_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FETCH,
        S_LOAD,
        S_START,
        S_WAIT,
        S_FIN
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   len;
    logic [WD_W-1:0]   wd;
    logic [1:0]        ma_op_q;
    logic              end_q;
    logic              unused_rsvd;

    // The reserved instruction bits have no function.
    assign unused_rsvd = ^rom_data[6:5];

    // Sequencer state, program counter, watchdog and per-instruction latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= '0;
            len     <= '0;
            wd      <= '0;
            ma_op_q <= '0;
            end_q   <= 1'b0;
        end else if (state != S_IDLE && abort) begin
            // Abort overrides every other transition.
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        len   <= prog_len;
                        pc    <= '0;
                        state <= S_CLR;
                    end
                end
                S_CLR: begin
                    state <= (len == '0) ? S_FIN : S_FETCH;
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    ma_op_q <= rom_data[4:3];
                    end_q   <= rom_data[7];
                    state   <= S_START;
                end
                S_START: begin
                    wd    <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // ma_done beats a simultaneous watchdog expiry.
                    if (ma_done) begin
                        if (end_q || pc == PC_W'(len - PC_W'(1))) begin
                            state <= S_FIN;
                        end else begin
                            pc    <= pc + PC_W'(1);
                            state <= S_FETCH;
                        end
                    end else if (wd == WD_MAX) begin
                        state <= S_IDLE;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode of the state and internal registers. Abort, ma_done and
    // rom_data gate the decode in the cycle where they take effect.
    logic aborting;
    logic wd_expire;

    assign busy      = (state != S_IDLE);
    assign aborting  = busy && abort;
    assign wd_expire = (state == S_WAIT) && (wd == WD_MAX) && !ma_done && !abort;

    assign rom_addr = pc;
    assign ma_op    = ma_op_q;
    assign err      = wd_expire;
    assign x_clr    = (state == S_CLR) || aborting || wd_expire;
    assign x_en     = (state == S_LOAD) && !abort;
    assign x_op     = x_en ? rom_data[2:0] : 3'd0;
    assign ma_start = (state == S_START) && !abort;
    assign done     = (state == S_FIN) && !abort;

endmodule

// File: tb/tb_ec_x_seq.sv
// Directed bench for ec_x_seq with an event scoreboard: each expected output
// event (clear, load, start, done, err) is queued with its stimulus and
// compared in order as the DUT produces it.
module tb_ec_x_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [5:0] prog_len;
    logic [5:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic [2:0] x_op;
    logic       x_en;
    logic       x_clr;
    logic [1:0] ma_op;
    logic       ma_start;
    logic       ma_done = 1'b0;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ec_x_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .prog_len (prog_len),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .x_op     (x_op),
        .x_en     (x_en),
        .x_clr    (x_clr),
        .ma_op    (ma_op),
        .ma_start (ma_start),
        .ma_done  (ma_done),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Synchronous ROM, one-cycle read latency.
    logic [7:0] rom [64];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Event = {x_clr, x_en, ma_start, done, err, x_op, ma_op (only on ma_start)}.
    typedef logic [9:0] ev_t;
    ev_t exp_q[$];
    ev_t obs;
    ev_t expv;
    int  max_addr = 0;
    logic md_en = 1'b1;

    function automatic ev_t ev(input logic c, input logic e, input logic s,
                               input logic d, input logic r,
                               input logic [2:0] xo, input logic [1:0] mo);
        return {c, e, s, d, r, xo, mo};
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (busy && int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
        if (x_clr || x_en || ma_start || done || err) begin
            obs = {x_clr, x_en, ma_start, done, err, x_op, (ma_start ? ma_op : 2'b00)};
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_event observed=%h required=none", obs);
            end
            if (exp_q.size() != 0) begin
                expv = exp_q.pop_front();
                checks++;
                assert (obs === expv) else begin
                    failures++;
                    $error("FAIL event observed=%h required=%h", obs, expv);
                end
            end
        end
    end

    // Arithmetic-unit model: ma_done three cycles after each ma_start.
    always begin
        @(negedge clk);
        if (ma_start && md_en) begin
            repeat (3) @(posedge clk);
            #1 ma_done = 1'b1;
            @(posedge clk);
            #1 ma_done = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h required=%0h", tag, o, e);
        end
    endtask

    // Bounded wait: sel 0 = ma_start, 1 = x_en, 2 = idle.
    task automatic wait_for(input string tag, input int sel, input int limit);
        int n = 0;
        logic hit;
        hit = 1'b0;
        while (!hit && n < limit) begin
            case (sel)
                0:       hit = ma_start;
                1:       hit = x_en;
                default: hit = !busy;
            endcase
            if (!hit) begin
                step();
                n++;
            end
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    task automatic pulse_start(input logic [5:0] len);
        prog_len = len;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        prog_len = 6'd0;
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        repeat (2) step();
        chk("reset_outs", 32'({busy, done, err, x_clr, x_en, ma_start, x_op, ma_op, rom_addr}), 32'd0);
        rst_n = 1'b1;
        step();

        // Two-instruction program.
        rom[0] = 8'h04;
        rom[1] = 8'h0E;
        exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 2'd0));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 3'd4, 2'd0));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 3'd0, 2'd0));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 3'd6, 2'd0));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 3'd0, 2'd1));
        exp_q.push_back(ev(0, 0, 0, 1, 0, 3'd0, 2'd0));
        pulse_start(6'd2);
        chk("t1_clr", 32'(x_clr), 32'd1);
        wait_for("t1_idle", 2, 200);
        chk("t1_drain", 32'(exp_q.size()), 32'd0);

        // End flag on instruction 1 of a five-instruction program.
        rom[0] = 8'h0A;
        rom[1] = 8'h91;
        rom[2] = 8'h04;
        max_addr = 0;
        exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 2'd0));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 3'd2, 2'd0));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 3'd0, 2'd1));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 3'd1, 2'd0));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 3'd0, 2'd2));
        exp_q.push_back(ev(0, 0, 0, 1, 0, 3'd0, 2'd0));
        pulse_start(6'd5);
        wait_for("t2_idle", 2, 200);
        chk("t2_max_addr", 32'(max_addr), 32'd1);
        chk("t2_drain", 32'(exp_q.size()), 32'd0);

        // Empty program: CLR then FIN.
        exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 2'd0));
        exp_q.push_back(ev(0, 0, 0, 1, 0, 3'd0, 2'd0));
        pulse_start(6'd0);
        chk("t3_clr", 32'({x_clr, x_en}), 32'b10);
        step();
        chk("t3_done", 32'({done, ma_start}), 32'b10);
        step();
        chk("t3_idle", 32'(busy), 32'd0);
        chk("t3_drain", 32'(exp_q.size()), 32'd0);

        // Watchdog expiry with ma_done withheld.
        md_en = 1'b0;
        rom[0] = 8'h03;
        exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 2'd0));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 3'd3, 2'd0));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 3'd0, 2'd0));
        exp_q.push_back(ev(1, 0, 0, 0, 1, 3'd0, 2'd0));
        pulse_start(6'd1);
        wait_for("t4_start", 0, 20);
        step();
        repeat (254) step();
        chk("t4_err_early", 32'(err), 32'd0);
        step();
        chk("t4_err", 32'({err, x_clr, busy, done}), 32'b1110);
        step();
        chk("t4_busy_drop", 32'(busy), 32'd0);
        chk("t4_drain", 32'(exp_q.size()), 32'd0);

        // Abort during WAIT, with a start pulse while busy.
        rom[0] = 8'h1D;
        exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 2'd0));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 3'd5, 2'd0));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 3'd0, 2'd3));
        exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 2'd0));
        pulse_start(6'd3);
        wait_for("t5_start", 0, 20);
        repeat (5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        abort = 1'b1;
        #1;
        chk("t5_abort", 32'({x_clr, done, err, busy}), 32'b1001);
        step();
        abort = 1'b0;
        chk("t5_idle", 32'(busy), 32'd0);
        repeat (5) step();
        chk("t5_start_ignored", 32'(busy), 32'd0);
        chk("t5_drain", 32'(exp_q.size()), 32'd0);

        // Reset during LOAD, then a fresh run from pc=0.
        md_en = 1'b1;
        rom[0] = 8'h04;
        exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 2'd0));
        pulse_start(6'd2);
        wait_for("t6_load", 1, 20);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_outs", 32'({busy, done, err, x_clr, x_en, ma_start, x_op, ma_op, rom_addr}), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("t6_no_pulse", 32'({done, err, busy}), 32'd0);
        chk("t6_drain_a", 32'(exp_q.size()), 32'd0);
        rom[0] = 8'h1F;
        exp_q.push_back(ev(1, 0, 0, 0, 0, 3'd0, 2'd0));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 3'd7, 2'd0));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 3'd0, 2'd3));
        exp_q.push_back(ev(0, 0, 0, 1, 0, 3'd0, 2'd0));
        pulse_start(6'd1);
        chk("t6_pc0", 32'({x_clr, rom_addr}), 32'h40);
        wait_for("t6_idle", 2, 200);
        chk("t6_drain_b", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
